// File: rtl/switch_debounce_if.sv
// Switch conditioning bus: raw board levels and event clear in,
// debounced levels, edge pulses and the sticky event flag out.
interface switch_debounce_if #(
  parameter int WIDTH = 10
);

  logic [WIDTH-1:0] sw_raw;
  logic             evt_clr;
  logic [WIDTH-1:0] sw_stable;
  logic [WIDTH-1:0] sw_rise;
  logic [WIDTH-1:0] sw_fall;
  logic             sw_event;

  // Side that owns the switches and consumes the conditioned result
  modport master (
    output sw_raw,
    output evt_clr,
    input  sw_stable,
    input  sw_rise,
    input  sw_fall,
    input  sw_event
  );

  // The debouncer itself
  modport slave (
    input  sw_raw,
    input  evt_clr,
    output sw_stable,
    output sw_rise,
    output sw_fall,
    output sw_event
  );

endinterface

// File: rtl/switch_debounce.sv
// Per-bit switch debouncer: two-flop synchronizer, an independent
// qualification counter per bit, registered rise/fall pulses and a
// sticky event flag that software clears with evt_clr.
module switch_debounce #(
  parameter int WIDTH           = 10,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             reset_n,
  switch_debounce_if.slave bus
);

  localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] stable_q;
  logic [WIDTH-1:0] rise_q;
  logic [WIDTH-1:0] fall_q;
  logic             event_q;

  // Bring the asynchronous switch levels into the clock domain
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= bus.sw_raw;
      sync2 <= sync1;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic [CNT_W-1:0] cnt;
    logic             stable_b;
    logic             rise_b;
    logic             fall_b;

    // Accept a new level only after it persists for a full window; any
    // bounce back to the accepted level restarts the window
    always_ff @(posedge clk) begin
      if (!reset_n) begin
        cnt      <= '0;
        stable_b <= 1'b0;
        rise_b   <= 1'b0;
        fall_b   <= 1'b0;
      end else begin
        rise_b <= 1'b0;
        fall_b <= 1'b0;
        if (sync2[i] == stable_b) begin
          cnt <= '0;
        end else if (cnt < CNT_LAST) begin
          cnt <= cnt + 1'b1;
        end else begin
          cnt      <= '0;
          stable_b <= sync2[i];
          rise_b   <= sync2[i];
          fall_b   <= ~sync2[i];
        end
      end
    end

    assign stable_q[i] = stable_b;
    assign rise_q[i]   = rise_b;
    assign fall_q[i]   = fall_b;
  end

  // Sticky event: any pulse sets it, and setting wins over a clear
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      event_q <= 1'b0;
    end else if ((|rise_q) || (|fall_q)) begin
      event_q <= 1'b1;
    end else if (bus.evt_clr) begin
      event_q <= 1'b0;
    end
  end

  assign bus.sw_stable = stable_q;
  assign bus.sw_rise   = rise_q;
  assign bus.sw_fall   = fall_q;
  assign bus.sw_event  = event_q;

endmodule

// File: tb/tb_switch_debounce.sv
// Directed bench for switch_debounce with a short window (4 cycles).
module tb_switch_debounce;

  localparam int WIDTH = 10;
  localparam int DC    = 4;

  logic clk = 1'b0;
  logic reset_n;
  int   compared   = 0;
  int   mismatched = 0;

  switch_debounce_if #(.WIDTH(WIDTH)) bus ();

  switch_debounce #(
    .WIDTH           (WIDTH),
    .DEBOUNCE_CYCLES (DC)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Hard stop in case the sequence ever stalls
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [WIDTH-1:0] raw, input logic clr);
    bus.sw_raw  = raw;
    bus.evt_clr = clr;
  endtask

  task automatic checkField(input string tag, input string field,
                            input logic [WIDTH-1:0] observed,
                            input logic [WIDTH-1:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s.%s: observed %h expected %h", tag, field, observed, expected);
    end
  endtask

  task automatic checkOutput(input string tag,
                             input logic [WIDTH-1:0] exp_stable,
                             input logic [WIDTH-1:0] exp_rise,
                             input logic [WIDTH-1:0] exp_fall,
                             input logic             exp_event);
    checkField(tag, "stable", bus.sw_stable, exp_stable);
    checkField(tag, "rise",   bus.sw_rise,   exp_rise);
    checkField(tag, "fall",   bus.sw_fall,   exp_fall);
    checkField(tag, "event",  {9'd0, bus.sw_event}, {9'd0, exp_event});
  endtask

  initial begin
    // Reset, then bit 0 held high: accepted on edge 6, event on edge 7
    reset_n = 1'b0;
    applyStimulus(10'h000, 1'b0);
    tick();
    tick();
    checkOutput("reset", 10'h000, 10'h000, 10'h000, 1'b0);
    reset_n = 1'b1;
    applyStimulus(10'h001, 1'b0);
    for (int e = 1; e <= 5; e++) begin
      tick();
      checkOutput("rise_wait", 10'h000, 10'h000, 10'h000, 1'b0);
    end
    tick();
    checkOutput("rise_accept", 10'h001, 10'h001, 10'h000, 1'b0);
    tick();
    checkOutput("rise_after", 10'h001, 10'h000, 10'h000, 1'b1);

    // Clearing the event, then clearing again while already clear
    applyStimulus(10'h001, 1'b1);
    tick();
    checkOutput("evt_clr", 10'h001, 10'h000, 10'h000, 1'b0);
    tick();
    checkOutput("evt_clr_idle", 10'h001, 10'h000, 10'h000, 1'b0);

    // Clear on the same cycle as a rise pulse loses; next idle clear wins
    applyStimulus(10'h003, 1'b0);
    for (int e = 1; e <= 5; e++) begin
      tick();
      checkOutput("bit1_wait", 10'h001, 10'h000, 10'h000, 1'b0);
    end
    tick();
    checkOutput("bit1_accept", 10'h003, 10'h002, 10'h000, 1'b0);
    applyStimulus(10'h003, 1'b1);
    tick();
    checkOutput("clr_vs_set", 10'h003, 10'h000, 10'h000, 1'b1);
    tick();
    checkOutput("clr_after", 10'h003, 10'h000, 10'h000, 1'b0);
    applyStimulus(10'h003, 1'b0);

    // Bounce: high 3, low 1, high again -> accepted 6 edges after final rise
    reset_n = 1'b0;
    applyStimulus(10'h000, 1'b0);
    tick();
    checkOutput("reset2", 10'h000, 10'h000, 10'h000, 1'b0);
    reset_n = 1'b1;
    tick();
    checkOutput("release2", 10'h000, 10'h000, 10'h000, 1'b0);
    applyStimulus(10'h001, 1'b0);
    for (int e = 1; e <= 3; e++) begin
      tick();
      checkOutput("bounce_hi", 10'h000, 10'h000, 10'h000, 1'b0);
    end
    applyStimulus(10'h000, 1'b0);
    tick();
    checkOutput("bounce_lo", 10'h000, 10'h000, 10'h000, 1'b0);
    applyStimulus(10'h001, 1'b0);
    for (int e = 1; e <= 5; e++) begin
      tick();
      checkOutput("bounce_requal", 10'h000, 10'h000, 10'h000, 1'b0);
    end
    tick();
    checkOutput("bounce_accept", 10'h001, 10'h001, 10'h000, 1'b0);
    tick();
    checkOutput("bounce_after", 10'h001, 10'h000, 10'h000, 1'b1);

    // Nine bits rise together, then every other bit falls together
    applyStimulus(10'h3FF, 1'b0);
    for (int e = 1; e <= 5; e++) begin
      tick();
      checkOutput("multi_rise_wait", 10'h001, 10'h000, 10'h000, 1'b1);
    end
    tick();
    checkOutput("multi_rise", 10'h3FF, 10'h3FE, 10'h000, 1'b1);
    tick();
    checkOutput("multi_rise_after", 10'h3FF, 10'h000, 10'h000, 1'b1);
    applyStimulus(10'h2AA, 1'b0);
    for (int e = 1; e <= 5; e++) begin
      tick();
      checkOutput("multi_fall_wait", 10'h3FF, 10'h000, 10'h000, 1'b1);
    end
    tick();
    checkOutput("multi_fall", 10'h2AA, 10'h000, 10'h155, 1'b1);
    tick();
    checkOutput("multi_fall_after", 10'h2AA, 10'h000, 10'h000, 1'b1);

    // Reset in the middle of qualifying bit 7 discards the partial count
    reset_n = 1'b0;
    applyStimulus(10'h000, 1'b0);
    tick();
    reset_n = 1'b1;
    tick();
    applyStimulus(10'h080, 1'b0);
    for (int e = 1; e <= 4; e++) begin
      tick();
      checkOutput("midq_wait", 10'h000, 10'h000, 10'h000, 1'b0);
    end
    reset_n = 1'b0;
    tick();
    checkOutput("midq_reset", 10'h000, 10'h000, 10'h000, 1'b0);
    reset_n = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      tick();
      checkOutput("midq_requal", 10'h000, 10'h000, 10'h000, 1'b0);
    end
    tick();
    checkOutput("midq_accept", 10'h080, 10'h080, 10'h000, 1'b0);
    tick();
    checkOutput("midq_after", 10'h080, 10'h000, 10'h000, 1'b1);

    // Toggling every cycle never qualifies
    reset_n = 1'b0;
    applyStimulus(10'h000, 1'b0);
    tick();
    reset_n = 1'b1;
    tick();
    for (int n = 0; n < 100; n++) begin
      applyStimulus((n % 2 == 0) ? 10'h3FF : 10'h000, 1'b0);
      tick();
      checkOutput("toggle", 10'h000, 10'h000, 10'h000, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/switch_debounce.md
SWITCH_DEBOUNCE -- requirements
Module: switch_debounce

Interface
REQ-001 The module SHALL have parameter WIDTH, default 10: number of switch inputs conditioned.
REQ-002 The module SHALL have parameter DEBOUNCE_CYCLES, default 50000: consecutive cycles a new level must persist before it is accepted; legal range 2..65535.
REQ-003 Port clk  input  1: the single clock; all state changes on the rising edge.
REQ-004 Port reset_n  input  1: reset, synchronous and active-low.
REQ-005 Port sw_raw  input  WIDTH: asynchronous, bouncing board switch levels.
REQ-006 Port evt_clr  input  1: one-cycle request to clear sw_event.
REQ-007 Port sw_stable  output  WIDTH: debounced levels, driven to the memory block's switches input (read at address 0xC000_0000).
REQ-008 Port sw_rise  output  WIDTH: one-cycle pulse per bit when sw_stable goes 0->1.
REQ-009 Port sw_fall  output  WIDTH: one-cycle pulse per bit when sw_stable goes 1->0.
REQ-010 Port sw_event  output  1: sticky flag, set by any rise or fall.

Function
REQ-011 Each bit SHALL pass through a two-flop synchronizer (sync1, then sync2) before any other logic uses it.
REQ-012 Each bit SHALL own an independent counter of ceil(log2(DEBOUNCE_CYCLES)) bits; bits never share or interact.
REQ-013 Per bit, when sync2 equals sw_stable, the counter SHALL be cleared to 0 on that edge.
REQ-014 Per bit, when sync2 differs from sw_stable and counter < DEBOUNCE_CYCLES-1, the counter SHALL increment by 1.
REQ-015 Per bit, when sync2 differs from sw_stable and counter == DEBOUNCE_CYCLES-1, on that edge: sw_stable SHALL take sync2, the counter SHALL clear to 0, and the matching sw_rise or sw_fall bit SHALL assert for exactly that one following cycle.
REQ-016 A level change on sw_raw held constant SHALL appear on sw_stable exactly DEBOUNCE_CYCLES+2 rising edges after it is set up, counting the first sampling edge as edge 1.
REQ-017 Any return of sync2 to the sw_stable value before acceptance (a bounce) SHALL restart the qualification window from 0, with no output change.
REQ-018 sw_rise and sw_fall SHALL be registered, never both high on the same bit, and deasserted on every cycle without an accepted transition.
REQ-019 Several bits SHALL be able to accept transitions on the same edge; each asserts its own pulse bit.
REQ-020 sw_event SHALL set on the edge after any sw_rise or sw_fall bit is high, and stay set until cleared.
REQ-021 sw_event SHALL clear on the edge on which evt_clr is high, unless a rise/fall pulse is high on that same cycle, in which case set SHALL win and sw_event stays 1.
REQ-022 evt_clr while sw_event is 0 SHALL have no effect.
REQ-023 The counter SHALL never wrap; it saturates at DEBOUNCE_CYCLES-1 for at most one cycle before acceptance clears it.

Reset
REQ-024 While reset_n is low at a rising edge: sync1, sync2, counters, sw_stable, sw_rise, sw_fall and sw_event SHALL all become 0.
REQ-025 Reset asserted mid-qualification SHALL discard the partial count; counting restarts from 0 after release.
REQ-026 After reset release with a switch held high, that bit SHALL qualify normally and produce one sw_rise pulse DEBOUNCE_CYCLES+2 edges after release.
REQ-027 Outputs SHALL hold their reset values on the edge after reset_n returns high.

Verification (DEBOUNCE_CYCLES = 4, WIDTH = 10)
REQ-028 Reset, then sw_raw=10'h001 held -> sw_stable=10'h001 from edge 6, sw_rise=10'h001 for one cycle only, sw_event=1 from edge 7.
REQ-029 From sw_stable=10'h000: sw_raw bit0 high for 3 cycles, low for 1, high again -> sw_stable stays 10'h000 until 6 edges after the final rise; no earlier pulse.
REQ-030 From sw_stable=10'h3FF: sw_raw=10'h2AA held -> sw_fall=10'h155 pulsed on a single cycle, sw_rise=0 throughout, sw_stable=10'h2AA.
REQ-031 evt_clr asserted on the same cycle as a sw_rise pulse -> sw_event remains 1; evt_clr on the next idle cycle -> sw_event becomes 0.
REQ-032 Reset asserted 2 cycles into qualification of sw_raw=10'h080 -> all outputs 0; after release, sw_stable=10'h080 exactly 6 edges later.
REQ-033 sw_raw toggling every cycle for 100 cycles -> sw_stable, sw_rise, sw_fall unchanged at 0.
